mem_arbiter: RTL

- Sequences and shares the single external memory port (readM/writeM/address/data, inputReady/ackOutput) between the instruction-fetch requester and the data (load/store) requester of the 16-bit CPU.
- Replaces ad-hoc posedge/negedge driving of the port with one registered FSM and one access at a time.
- Each access uses a req/done handshake.

---
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for mem_arbiter.
//   master : the CPU side (drives i_req/i_addr, d_req/d_we/d_addr/d_wdata)
//   slave  : the arbiter (drives i_data/i_done, d_rdata/d_done, err, busy)
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_done;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_done;
  logic                 err;
  logic                 busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_data, i_done, d_rdata, d_done, err, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_data, i_done, d_rdata, d_done, err, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the instruction-fetch
// requester and the load/store requester. One registered FSM, one access at a
// time, round-robin grant when both sides ask in the same cycle.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   req_if (slave)       fetch/data req-done handshakes, err, busy
//   readM, writeM        memory read/write strobes (registered)
//   address              memory address (registered, stable per access)
//   data                 bidirectional memory data bus, driven only in D_WR
//   inputReady           memory read data valid
//   ackOutput            memory write accepted
//
// Optional: define MEM_TIMEOUT_EN to abort an access after TIMEOUT wait
// cycles (done pulses with err=1, read result forced to all ones).
module mem_arbiter #(
  parameter int          WORD_SIZE = 16,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_arbiter_if.slave         req_if,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput
);

  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;
  typedef enum logic {G_FETCH, G_DATA} grant_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be in 1..255");
  end

  state_t               state_q;
  grant_t               last_grant_q;
  logic                 readM_q, writeM_q, busy_q;
  logic [WORD_SIZE-1:0] address_q, wdata_q;
  logic [WORD_SIZE-1:0] i_data_q, d_rdata_q;
  logic                 i_done_q, d_done_q, err_q;
  logic                 i_elig, d_elig, grant_d, timed_out;

  // A side whose done is still high is finishing its handshake this cycle.
  assign i_elig  = req_if.i_req & ~i_done_q;
  assign d_elig  = req_if.d_req & ~d_done_q;
  assign grant_d = d_elig & (~i_elig | (last_grant_q == G_FETCH));

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_q;

  // wait_q holds the number of wait edges already seen; the edge that would
  // make it reach TIMEOUT is the abort edge.
  assign timed_out = (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n)            wait_q <= '0;
    else if (state_q == IDLE) wait_q <= '0;
    else                      wait_q <= wait_q + 8'd1;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= G_FETCH;
      readM_q      <= 1'b0;
      writeM_q     <= 1'b0;
      busy_q       <= 1'b0;
      address_q    <= '0;
      wdata_q      <= '0;
      i_data_q     <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            address_q    <= req_if.d_addr;
            wdata_q      <= req_if.d_wdata;
            last_grant_q <= G_DATA;
            busy_q       <= 1'b1;
            if (req_if.d_we) begin
              state_q  <= D_WR;
              writeM_q <= 1'b1;
            end else begin
              state_q <= D_RD;
              readM_q <= 1'b1;
            end
          end else if (i_elig) begin
            address_q    <= req_if.i_addr;
            last_grant_q <= G_FETCH;
            busy_q       <= 1'b1;
            state_q      <= I_RD;
            readM_q      <= 1'b1;
          end
        end
        I_RD: begin
          if (inputReady || timed_out) begin
            i_data_q <= inputReady ? data : '1;
            err_q    <= ~inputReady;
            i_done_q <= 1'b1;
            readM_q  <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        D_RD: begin
          if (inputReady || timed_out) begin
            d_rdata_q <= inputReady ? data : '1;
            err_q     <= ~inputReady;
            d_done_q  <= 1'b1;
            readM_q   <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        D_WR: begin
          if (ackOutput || timed_out) begin
            if (!ackOutput) d_rdata_q <= '1;
            err_q    <= ~ackOutput;
            d_done_q <= 1'b1;
            writeM_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data           = (state_q == D_WR) ? wdata_q : 'z;
  assign readM          = readM_q;
  assign writeM         = writeM_q;
  assign address        = address_q;
  assign req_if.i_data  = i_data_q;
  assign req_if.i_done  = i_done_q;
  assign req_if.d_rdata = d_rdata_q;
  assign req_if.d_done  = d_done_q;
  assign req_if.err     = err_q;
  assign req_if.busy    = busy_q;

endmodule
